// File: rtl/reg_10_bit_byte_reader.sv
// Captures a DATA_W-bit word and replays it as two BUS_W-bit beats (low, then zero-extended high).
// Optional macro HIGH_SKIP_EN: words with an all-zero high part are sent as a single beat.
module reg_10_bit_byte_reader #(
    parameter int DATA_W = 10,
    parameter int BUS_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              ld_ready,
    output logic              load_drop,
    output logic [BUS_W-1:0]  out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int HI_W = DATA_W - BUS_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] word;
    logic              accept;
`ifdef HIGH_SKIP_EN
    logic              single;
`endif

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_byte  = '0;
        out_last  = 1'b0;
        ld_ready  = 1'b0;
        case (state)
            IDLE: begin
                ld_ready = 1'b1;
            end
            LOW: begin
                out_valid = 1'b1;
                out_byte  = word[BUS_W-1:0];
`ifdef HIGH_SKIP_EN
                out_last  = single;
                ld_ready  = out_ready & single;
`endif
            end
            HIGH: begin
                out_valid            = 1'b1;
                out_byte[HI_W-1:0]   = word[DATA_W-1:BUS_W];
                out_last             = 1'b1;
                ld_ready             = out_ready;
            end
            default: ;
        endcase

        accept = load & ld_ready;

        case (state)
            IDLE: begin
                if (accept) state_nxt = LOW;
            end
            LOW: begin
                if (out_ready) begin
`ifdef HIGH_SKIP_EN
                    if (single) state_nxt = accept ? LOW : IDLE;
                    else        state_nxt = HIGH;
`else
                    state_nxt = HIGH;
`endif
                end
            end
            HIGH: begin
                // Final-beat handshake may overlap the next accept: no idle bubble.
                if (out_ready) state_nxt = accept ? LOW : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            word      <= '0;
            load_drop <= 1'b0;
        end else begin
            state     <= state_nxt;
            load_drop <= load & ~ld_ready;
            if (accept) word <= data;
        end
    end

`ifdef HIGH_SKIP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      single <= 1'b0;
        else if (accept) single <= (data[DATA_W-1:BUS_W] == '0);
    end
`endif

endmodule
